// File: rtl/bcd_cnt_pkg.sv
// ----------------------------------------------------------------------------
// bcd_cnt_pkg
// Shared definitions for the prescaled BCD counter: digit type, the legal
// digit bounds and a clamp helper that forces a nibble back into 0..9.
// Optional feature macro used by the counter: BCD_CNT_LOAD_EN (parallel load).
// ----------------------------------------------------------------------------
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Any nibble above 9 is not a decimal digit; saturate it to 9.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t value);
        bcd_digit_t result;
        if (value > BCD_MAX) begin
            result = BCD_MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
// One decimal digit of the counter chain. Steps up or down by one when en_in
// (carry/borrow in) is high, with clear and load taking priority.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   en_in  carry (up) / borrow (down) from the next lower digit or the tick
//   up     direction, 1 = increment, 0 = decrement
//   clr    synchronous clear to 0
//   ld     synchronous load of ld_val (clamped to 9)
//   ld_val load value for this digit
//   digit  registered digit value, always 0..9
//   co     carry/borrow out to the next higher digit (combinational)
// ----------------------------------------------------------------------------
module bcd_digit
    import bcd_cnt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_in,
    input  logic       up,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t digit,
    output logic       co
);

    bcd_digit_t digit_d;
    bcd_digit_t digit_q;

    // A digit passes the step on only when it is about to wrap in the chosen direction.
    always_comb begin
        if (up) begin
            co = en_in & (digit_q == BCD_MAX);
        end else begin
            co = en_in & (digit_q == BCD_MIN);
        end
    end

    // Next digit value: clear, then load, then a single up/down step.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = BCD_MIN;
        end else if (ld) begin
            digit_d = bcd_clamp(ld_val);
        end else if (en_in) begin
            if (up) begin
                // >= rather than == keeps the digit decimal even if it were ever corrupted.
                if (digit_q >= BCD_MAX) begin
                    digit_d = BCD_MIN;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == BCD_MIN) begin
                    digit_d = BCD_MAX;
                end else if (digit_q > BCD_MAX) begin
                    digit_d = BCD_MAX;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_prescale_cnt.sv
// ----------------------------------------------------------------------------
// bcd_prescale_cnt
// Multi-digit BCD up/down counter that advances once every PRESCALE enabled
// clocks, wrapping at 99..9 / 0 and flagging the wrap on carry.
// Optional feature: define BCD_CNT_LOAD_EN to add the load/load_val ports
// (synchronous parallel load, each digit clamped to 9).
// Parameters:
//   PRESCALE  enabled clocks per count step (1..65536)
//   DIGITS    number of BCD digits (1..8)
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        count enable; prescaler and digits hold when low
//   clr       synchronous clear of prescaler and digits (highest priority)
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load (BCD_CNT_LOAD_EN only)
//   load_val  BCD load value, digit 0 in [3:0] (BCD_CNT_LOAD_EN only)
//   out       current BCD value, digit 0 in [3:0]
//   tick      high in a cycle whose closing edge performs a count step
//   carry     high in a step cycle in which the whole value wraps
// ----------------------------------------------------------------------------
module bcd_prescale_cnt
    import bcd_cnt_pkg::*;
#(
    parameter int PRESCALE = 100,
    parameter int DIGITS   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic                up,
`ifdef BCD_CNT_LOAD_EN
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
`endif
    output logic [4*DIGITS-1:0] out,
    output logic                tick,
    output logic                carry
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    logic                load_s;
    logic [4*DIGITS-1:0] load_val_s;
    logic                step_s;
    logic [DIGITS:0]     chain_s;
    logic [PW-1:0]       presc_d;
    logic [PW-1:0]       presc_q;

`ifdef BCD_CNT_LOAD_EN
    assign load_s     = load;
    assign load_val_s = load_val;
`else
    assign load_s     = 1'b0;
    assign load_val_s = '0;
`endif

    // A step needs enable and a full prescale period, and never happens under clr/load.
    assign step_s = en & (presc_q == PRESC_LAST) & ~clr & ~load_s;

    // Prescaler next value; with PRESCALE=1 every branch yields 0 so the register is constant.
    always_comb begin
        presc_d = presc_q;
        if (clr || load_s) begin
            presc_d = '0;
        end else if (step_s) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_q + PRESC_ONE;
        end else begin
            presc_d = presc_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // The step enters digit 0; each digit's carry/borrow enables the next one up.
    assign chain_s[0] = step_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .en_in  (chain_s[g]),
            .up     (up),
            .clr    (clr),
            .ld     (load_s),
            .ld_val (load_val_s[4*g +: 4]),
            .digit  (out[4*g +: 4]),
            .co     (chain_s[g+1])
        );
    end

    assign tick  = step_s;
    // Carry out of the top digit already implies step & every digit at its limit.
    assign carry = chain_s[DIGITS];

endmodule

// File: tb/tb_bcd_prescale_cnt.sv
module tb_bcd_prescale_cnt;

    logic        clk = 1'b0;
    logic        rst_r = 1'b0;
    logic        en_r = 1'b0;
    logic        clr_r = 1'b0;
    logic        up_r = 1'b1;
    logic        load_r = 1'b0;
    logic [11:0] load_val_r = 12'd0;

    logic [7:0]  out_a;
    logic [11:0] out_b;
    logic [7:0]  out_c;
    logic [2:0]  tick_s;
    logic [2:0]  carry_s;
    logic [11:0] out_s [3];

    assign out_s[0] = {4'd0, out_a};
    assign out_s[1] = out_b;
    assign out_s[2] = {4'd0, out_c};

    int total = 0;
    int bad   = 0;

    // model: three instances with different PRESCALE/DIGITS
    int p_cfg   [3] = '{100, 1, 10};
    int d_cfg   [3] = '{2, 3, 2};
    int mod_cfg [3] = '{100, 1000, 100};
    int m_presc [3] = '{0, 0, 0};
    int m_val   [3] = '{0, 0, 0};
    int tick_cnt[3] = '{0, 0, 0};
    logic [1:0] last_tc [3];

    logic [1:0]  q_tc [$];
    logic [11:0] q_out [$];

    always #5 clk = ~clk;

    bcd_prescale_cnt #(.PRESCALE(100), .DIGITS(2)) dut_a (
        .clk(clk), .rst(rst_r), .en(en_r), .clr(clr_r), .up(up_r),
`ifdef BCD_CNT_LOAD_EN
        .load(load_r), .load_val(load_val_r[7:0]),
`endif
        .out(out_a), .tick(tick_s[0]), .carry(carry_s[0]));

    bcd_prescale_cnt #(.PRESCALE(1), .DIGITS(3)) dut_b (
        .clk(clk), .rst(rst_r), .en(en_r), .clr(clr_r), .up(up_r),
`ifdef BCD_CNT_LOAD_EN
        .load(load_r), .load_val(load_val_r),
`endif
        .out(out_b), .tick(tick_s[1]), .carry(carry_s[1]));

    bcd_prescale_cnt #(.PRESCALE(10), .DIGITS(2)) dut_c (
        .clk(clk), .rst(rst_r), .en(en_r), .clr(clr_r), .up(up_r),
`ifdef BCD_CNT_LOAD_EN
        .load(load_r), .load_val(load_val_r[7:0]),
`endif
        .out(out_c), .tick(tick_s[2]), .carry(carry_s[2]));

    function automatic logic [11:0] to_bcd(input int v, input int d);
        logic [11:0] r;
        int x;
        r = 12'd0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_dec(input logic [11:0] lv, input int d);
        int v;
        int w;
        int dig;
        v = 0;
        w = 1;
        for (int i = 0; i < d; i++) begin
            dig = int'(lv[4*i +: 4]);
            if (dig > 9) dig = 9;
            v = v + dig * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, check tick/carry before the edge, out after it
    task automatic cycle(input logic e, input logic c, input logic u, input logic l,
                         input logic [11:0] lv);
        logic t;
        logic cy;
        logic [1:0] exp_tc;
        @(negedge clk);
        en_r = e; clr_r = c; up_r = u; load_r = l; load_val_r = lv;
        #1;
        for (int k = 0; k < 3; k++) begin
            t  = e && !c && !l && (m_presc[k] == p_cfg[k] - 1);
            cy = t && (u ? (m_val[k] == mod_cfg[k] - 1) : (m_val[k] == 0));
            q_tc.push_back({t, cy});
        end
        for (int k = 0; k < 3; k++) begin
            exp_tc = q_tc.pop_front();
            check($sformatf("tick_carry[%0d]", k), {30'd0, tick_s[k], carry_s[k]}, {30'd0, exp_tc});
            last_tc[k] = {tick_s[k], carry_s[k]};
            if (tick_s[k]) tick_cnt[k]++;
        end
        for (int k = 0; k < 3; k++) begin
            if (c) begin
                m_presc[k] = 0;
                m_val[k]   = 0;
            end else if (l) begin
                m_presc[k] = 0;
                m_val[k]   = load_dec(lv, d_cfg[k]);
            end else if (e) begin
                if (m_presc[k] == p_cfg[k] - 1) begin
                    m_presc[k] = 0;
                    m_val[k] = u ? (m_val[k] + 1) % mod_cfg[k]
                                 : (m_val[k] + mod_cfg[k] - 1) % mod_cfg[k];
                end else begin
                    m_presc[k]++;
                end
            end
            q_out.push_back(to_bcd(m_val[k], d_cfg[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out[%0d]", k), {20'd0, out_s[k]}, {20'd0, q_out.pop_front()});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] held_c;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            q_tc.push_back(2'b00);
            q_out.push_back(12'd0);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_tc[%0d]", k), {30'd0, tick_s[k], carry_s[k]}, {30'd0, q_tc.pop_front()});
            check($sformatf("rst_out[%0d]", k), {20'd0, out_s[k]}, {20'd0, q_out.pop_front()});
        end
        @(negedge clk);
        rst_r = 1'b1;

        // 1000 enabled cycles counting up
        for (int k = 0; k < 3; k++) tick_cnt[k] = 0;
        for (int i = 0; i < 1000; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);
        check("a_tick_count", 32'(tick_cnt[0]), 32'd10);
        check("a_out_after_1000", {20'd0, out_s[0]}, 32'h10);
        check("b_wrapped_to_zero", {20'd0, out_s[1]}, 32'h000);

        // down wrap from zero
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 12'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        check("b_down_wrap_carry", {30'd0, last_tc[1]}, 32'd3);
        check("b_down_wrap_val", {20'd0, out_s[1]}, 32'h999);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
        check("b_down_next_carry", {30'd0, last_tc[1]}, 32'd2);
        check("b_down_next_val", {20'd0, out_s[1]}, 32'h998);

        // enable gap keeps prescaler phase
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 12'd0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);
        held_c = out_s[2];
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
        check("c_hold_while_disabled", {20'd0, out_s[2]}, {20'd0, held_c});
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);
        check("c_reenable_1_tick", {31'd0, last_tc[2][1]}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);
        check("c_reenable_2_tick", {31'd0, last_tc[2][1]}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);
        check("c_reenable_3_tick", {31'd0, last_tc[2][1]}, 32'd1);
        check("c_step_value", {20'd0, out_s[2]}, 32'h01);

`ifdef BCD_CNT_LOAD_EN
        // clr beats load, both mask tick/carry
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h047);
        check("prio_b_tc", {30'd0, last_tc[1]}, 32'd0);
        check("prio_a_out", {20'd0, out_s[0]}, 32'h00);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'h047);
        check("load_a_out", {20'd0, out_s[0]}, 32'h47);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'h0AF);
        check("clamp_a_out", {20'd0, out_s[0]}, 32'h99);
        check("clamp_b_out", {20'd0, out_s[1]}, 32'h099);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);
`endif

        // mixed pseudo-random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                  1'($urandom_range(0, 1)), 1'b0, 12'd0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);

        // asynchronous reset mid-prescale, checked before the next clock edge
        @(posedge clk);
        #2;
        rst_r = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            m_presc[k] = 0;
            m_val[k]   = 0;
            q_out.push_back(12'd0);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async_rst_out[%0d]", k), {20'd0, out_s[k]}, {20'd0, q_out.pop_front()});
        end
        @(negedge clk);
        en_r = 1'b0;
        @(negedge clk);
        rst_r = 1'b1;
        for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 12'd0);
        check("c_after_reset", {20'd0, out_s[2]}, 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
